// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
//
// Round-robin arbiter/sequencer that shares a single sequential Booth
// multiplier core among NREQ requesters (FPU mantissa-multiply clients).
// One job is in flight at a time: accept operands from the granted
// requester, pulse the core, wait for its done pulse, then hand the 2N-bit
// product back to the same requester over a response handshake.
//
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN
//   When defined, a watchdog ends a WAIT that has lasted TIMEOUT cycles,
//   returning resp_r=0 with resp_err=1. When undefined, WAIT lasts until
//   mul_done and resp_err is constant 0.
//
// Parameters:
//   N       operand width (two's complement); product is 2N bits
//   NREQ    number of requesters (>= 2)
//   TIMEOUT watchdog limit in cycles (used only with the optional feature)
//
// Ports:
//   clk, rstn               clock (rising edge), async active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot)
//   req_m, req_q            packed operands, requester i at [i*N +: N]
//   mul_start               one-cycle start pulse to the core
//   mul_m, mul_q            operands to the core, stable start..done
//   mul_done, mul_r         core completion pulse and product
//   resp_valid/resp_ready   one-hot response handshake to the owner
//   resp_r                  product returned to the owner
//   resp_err                watchdog timeout flag
//   busy                    high whenever not IDLE
// ---------------------------------------------------------------------------
module booth_mul_arbiter #(
  parameter int N       = 6,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_q,
  output logic              mul_start,
  output logic [N-1:0]      mul_m,
  output logic [N-1:0]      mul_q,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_r,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [2*N-1:0]    resp_r,
  output logic              resp_err,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2) begin : g_cfg_nreq
    $error("booth_mul_arbiter: NREQ must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_cfg_timeout
    $error("booth_mul_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [IW-1:0] rr_ptr;    // first requester searched in IDLE
  logic [IW-1:0] grant;     // owner of the job in flight
  logic [IW-1:0] pick;      // round-robin winner this cycle
  logic          pick_vld;  // any requester present
  logic          resp_ack;  // owner accepted the response
  logic          tmo_hit;   // watchdog expires at the coming edge

  assign resp_ack = resp_ready[grant];

  // -------------------------------------------------------------------------
  // Round-robin search: rr_ptr, rr_ptr+1, ... modulo NREQ; first valid wins.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!pick_vld && req_valid[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)             state_nxt = ISSUE;
      ISSUE:                             state_nxt = WAIT;
      WAIT:    if (mul_done || tmo_hit)  state_nxt = RESP;
      RESP:    if (resp_ack)             state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mul_start  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      // req_ready is combinational from req_valid, so it is gated with rstn
      // to keep every output low while reset is held.
      IDLE:    if (pick_vld && rstn) req_ready[pick] = 1'b1;
      ISSUE:   mul_start = 1'b1;
      RESP:    resp_valid[grant] = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: grant/operand capture, product capture, round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
      grant  <= '0;
      mul_m  <= '0;
      mul_q  <= '0;
      resp_r <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant <= pick;
        mul_m <= req_m[pick*N +: N];
        mul_q <= req_q[pick*N +: N];
      end
      if (state == WAIT) begin
        if (mul_done) begin
          resp_r <= mul_r;
        end else if (tmo_hit) begin
          resp_r <= '0;
        end
      end
      // Pointer moves only when a job fully completes, so an abandoned or
      // stalled job never costs the owner its turn.
      if (state == RESP && resp_ack) begin
        rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Watchdog: cleared while issuing, counts WAIT cycles. Reaching TIMEOUT
  // (count TIMEOUT-1 at this edge) ends WAIT unless mul_done arrives in the
  // same cycle, in which case the real product wins.
  // -------------------------------------------------------------------------
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == WAIT && !mul_done && tmo_hit) begin
        err_q <= 1'b1;
      end else if (state == RESP && resp_ack) begin
        err_q <= 1'b0;
      end
    end
  end

  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
  assign resp_err = err_q;
`else
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_arbiter
//
// Directed bench for booth_mul_arbiter with a behavioural multiplier core.
// Expected responses (owner, product, error flag) are queued when operands
// are driven and popped when the DUT raises resp_valid.
// Timeout scenario is included only when BOOTH_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_booth_mul_arbiter;

  localparam int N       = 6;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_m;
  logic [NREQ*N-1:0] req_q;
  logic              mul_start;
  logic [N-1:0]      mul_m;
  logic [N-1:0]      mul_q;
  logic              mul_done = 1'b0;
  logic [2*N-1:0]    mul_r    = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [2*N-1:0]    resp_r;
  logic              resp_err;
  logic              busy;

  typedef struct {
    int             g;
    logic [2*N-1:0] r;
    logic           err;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] op_m [NREQ];
  logic [N-1:0] op_q [NREQ];

  int n_cmp = 0;
  int n_bad = 0;

  // core model controls (written only by the stimulus block)
  int core_lat  = 1;
  bit core_mute = 1'b0;
  int spur_req  = 0;

  // core model state (written only by the core block)
  bit             core_pend = 1'b0;
  int             core_cnt  = 0;
  int             spur_seen = 0;
  logic [2*N-1:0] core_prod = '0;

  booth_mul_arbiter #(
    .N       (N),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_m      (req_m),
    .req_q      (req_q),
    .mul_start  (mul_start),
    .mul_m      (mul_m),
    .mul_q      (mul_q),
    .mul_done   (mul_done),
    .mul_r      (mul_r),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_r     (resp_r),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural core: sees mul_start, raises mul_done core_lat cycles later
  // with the signed product of the operands it was handed.
  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (!rstn) begin
      core_pend = 1'b0;
    end else if (spur_req != spur_seen) begin
      spur_seen = spur_req;
      mul_done  = 1'b1;
      mul_r     = 12'h5A5;
    end else if (core_pend) begin
      if (core_cnt == 0) begin
        mul_done  = 1'b1;
        mul_r     = core_prod;
        core_pend = 1'b0;
      end else begin
        core_cnt--;
      end
    end
    if (rstn && mul_start && !core_mute) begin
      core_pend = 1'b1;
      core_cnt  = core_lat - 1;
      core_prod = (2*N)'(int'($signed(mul_m)) * int'($signed(mul_q)));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int g, input int m, input int q);
    op_m[g] = N'(m);
    op_q[g] = N'(q);
    req_m[g*N +: N] = N'(m);
    req_q[g*N +: N] = N'(q);
  endtask

  task automatic push(input int g, input int m, input int q);
    exp_t e;
    set_ops(g, m, q);
    e.g   = g;
    e.r   = (2*N)'(m * q);
    e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_tmo(input int g, input int m, input int q);
    exp_t e;
    set_ops(g, m, q);
    e.g   = g;
    e.r   = '0;
    e.err = 1'b1;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, ":req_ready"},  32'(req_ready),  0);
    chk({ph, ":mul_start"},  32'(mul_start),  0);
    chk({ph, ":mul_m"},      32'(mul_m),      0);
    chk({ph, ":mul_q"},      32'(mul_q),      0);
    chk({ph, ":resp_valid"}, 32'(resp_valid), 0);
    chk({ph, ":resp_r"},     32'(resp_r),     0);
    chk({ph, ":resp_err"},   32'(resp_err),   0);
    chk({ph, ":busy"},       32'(busy),       0);
  endtask

  // One complete job for expected owner g: grant, issue, wait, response,
  // optional backpressure of 'hold' cycles, then acceptance.
  task automatic do_job(input int g, input int lat, input int hold, input bit drop,
                        input bit spur_hold, input logic [NREQ-1:0] tease);
    int   n;
    int   exp_lat;
    exp_t e;
    #1;
    core_lat = lat;
    n = 0;
    while (req_ready === '0 && n < 50) begin
      step();
      n++;
    end
    chk("grant_wait", 32'(n < 50), 1);
    chk("req_ready", 32'(req_ready), 32'(onehot(g)));
    chk("busy_idle", 32'(busy), 0);
    step();
    if (drop) req_valid = '0;
    chk("mul_start", 32'(mul_start), 1);
    chk("mul_m", 32'(mul_m), 32'(op_m[g]));
    chk("mul_q", 32'(mul_q), 32'(op_q[g]));
    chk("ready_busy", 32'(req_ready), 0);
    chk("busy_issue", 32'(busy), 1);
    exp_lat = core_mute ? TIMEOUT + 1 : lat + 1;
    n = 0;
    do begin
      step();
      n++;
      if (resp_valid === '0) begin
        chk("start_once", 32'(mul_start), 0);
        chk("hold_m", 32'(mul_m), 32'(op_m[g]));
        chk("hold_q", 32'(mul_q), 32'(op_q[g]));
      end
    end while (resp_valid === '0 && n < 200);
    chk("resp_latency", 32'(n), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_valid", 32'(resp_valid), 32'(onehot(e.g)));
      chk("resp_r", 32'(resp_r), 32'(e.r));
      chk("resp_err", 32'(resp_err), 32'(e.err));
      resp_ready = ~onehot(g);
      req_valid  = req_valid | tease;
      if (spur_hold) spur_req++;
      for (int i = 0; i < hold; i++) begin
        step();
        chk("hold_resp_r", 32'(resp_r), 32'(e.r));
        chk("hold_resp_valid", 32'(resp_valid), 32'(onehot(e.g)));
        chk("hold_busy", 32'(busy), 1);
        chk("hold_no_ready", 32'(req_ready), 0);
      end
      req_valid  = req_valid & ~tease;
      resp_ready = onehot(g);
      step();
      resp_ready = '0;
      chk("resp_clear", 32'(resp_valid), 0);
      chk("back_idle", 32'(busy), 0);
      chk("err_clear", 32'(resp_err), 0);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_m      = '0;
    req_q      = '0;

    // Reset with every requester already valid: all outputs stay low.
    push(0, 5, 7);
    push(1, -3, 4);
    push(2, -7, -9);
    push(3, 12, -5);
    push(0, 5, 7);
    req_valid = '1;
    #3;
    chk_zero("reset");
    step();
    step();
    chk_zero("reset_held");
    rstn = 1'b1;

    // Continuous requests: grants 0,1,2,3,0.
    do_job(0, 1, 0, 1'b0, 1'b0, '0);
    do_job(1, 3, 0, 1'b0, 1'b0, '0);
    do_job(2, 1, 0, 1'b0, 1'b0, '0);
    do_job(3, 2, 0, 1'b0, 1'b0, '0);
    do_job(0, 1, 0, 1'b1, 1'b0, '0);

    // Single request: 3 * -2 = 12'hFFA; pointer moves to 2.
    push(1, 3, -2);
    req_valid = 4'b0010;
    do_job(1, 4, 0, 1'b1, 1'b0, '0);

    // Boundary operands; pointer at 2 grants 3 ahead of 1.
    push(3, -32, -32);
    push(1, 31, -1);
    req_valid = 4'b1010;
    do_job(3, 2, 0, 1'b0, 1'b0, '0);
    do_job(1, 2, 0, 1'b1, 1'b0, '0);

    // Backpressure: 10 held cycles, spurious done in RESP, requester 3
    // raises and drops valid while busy (no job may result).
    push(0, 13, -11);
    req_valid = 4'b0001;
    do_job(0, 3, 10, 1'b1, 1'b1, 4'b1000);
    spur_req++;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_resp", 32'(resp_valid), 0);
      chk("idle_ready", 32'(req_ready), 0);
    end

    // Move pointer to 3, then reset during WAIT.
    push(2, -1, -1);
    req_valid = 4'b0100;
    do_job(2, 1, 0, 1'b1, 1'b0, '0);
    push(0, 21, 2);
    req_valid = 4'b0001;
    core_lat  = 20;
    #1;
    chk("rst_pre_grant", 32'(req_ready), 32'(4'b0001));
    step();
    chk("rst_pre_start", 32'(mul_start), 1);
    step();
    step();
    chk("rst_pre_busy", 32'(busy), 1);
    req_valid = 4'b1001;
    #1;
    rstn = 1'b0;
    #1;
    chk_zero("rst_wait");
    void'(sb.pop_back());
    step();
    step();
    chk_zero("rst_wait_held");
    push(0, 21, 2);
    push(3, 10, 10);
    rstn = 1'b1;
    #1;
    chk("rst_no_stale", 32'(resp_valid), 0);
    do_job(0, 2, 0, 1'b0, 1'b0, '0);
    do_job(3, 2, 0, 1'b1, 1'b0, '0);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Core never answers: timeout response, late done ignored in RESP.
    core_mute = 1'b1;
    push_tmo(1, 7, 7);
    req_valid = 4'b0010;
    do_job(1, 1, 4, 1'b1, 1'b1, '0);
    core_mute = 1'b0;
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential Booth multiplier core among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues one multiply at a time to the core.
- Drives the core through a start/done interface, captures the 2N-bit product and returns it to the granted requester over a response handshake.
- Sits between the FPU mantissa-multiply clients and the shared multiplier.

Parameters:
- N, 6, operand width in bits (two's complement); product is 2N bits.
- NREQ, 4, number of requesters; must be ≥2.
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_m  in  NREQ*N  multiplicands; requester i uses slice [i*N +: N].
- req_q  in  NREQ*N  multipliers; requester i uses slice [i*N +: N].
- mul_start  out  1  one-cycle start pulse to the core.
- mul_m  out  N  multiplicand to the core, held stable from start until done.
- mul_q  out  N  multiplier to the core, held stable from start until done.
- mul_done  in  1  core completion pulse; mul_r is valid in the same cycle.
- mul_r  in  2N  core product.
- resp_valid  out  NREQ  one-hot response valid to the owning requester.
- resp_ready  in  NREQ  per-requester response accept.
- resp_r  out  2N  product returned to the requester.
- resp_err  out  1  timeout flag (tied 0 without the optional feature).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous on rstn low. state=IDLE, rr_ptr=0, and every output is 0: req_ready, mul_start, mul_m, mul_q, resp_valid, resp_r, resp_err, busy.
- Reset mid-operation abandons the job with no response. The core is assumed reset by the same rstn.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Choose grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - If any request is present: assert req_ready[g] combinationally this cycle.
  - On that edge, latch g, req_m[g] and req_q[g] into mul_m/mul_q, then go to ISSUE.
  - req_ready is 0 in all other states.
- ISSUE: mul_start=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - Hold mul_m/mul_q.
  - On mul_done=1: capture mul_r into resp_r, set resp_valid[g]=1, go to RESP.
  - A mul_done seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - Hold resp_valid[g] and resp_r until resp_ready[g]=1.
  - On that edge: clear resp_valid, set rr_ptr=(g+1) mod NREQ, return to IDLE.
  - resp_ready on other bits is ignored.
- Latency: accept edge → mul_start 1 cycle later → resp_valid 1 cycle after mul_done.
  - Minimum IDLE-to-IDLE time = core latency + 3 cycles.
- Fairness: rr_ptr only advances on response completion. A requester waits at most NREQ−1 jobs.
- Requester rules:
  - Operands are sampled only on the accept edge.
  - Dropping req_valid before accept is legal and produces no job.
  - Requester g may re-request while in RESP; it is not considered until IDLE.
- rr_ptr wraps from NREQ−1 to 0.
- No arithmetic is done here. mul_r passes through unmodified as signed 2N-bit; sign interpretation belongs to the core.

Optional Feature:
- Macro: BOOTH_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_done: go to RESP with resp_valid[g]=1, resp_r=0, resp_err=1.
  - resp_err clears when the response is accepted.
  - A late mul_done arriving after the timeout is ignored.
- Undefined: no counter; WAIT lasts indefinitely; resp_err is constant 0.

Test Plan:
- Single request (N=6, NREQ=4): requester 1 sends M=3, Q=6'b111110 (−2) → one mul_start pulse with mul_m=3, mul_q=62; after mul_done, resp_valid=4'b0010 with resp_r=12'hFFA; rr_ptr becomes 2.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0; exactly one req_ready high per job; no overlapping mul_start.
- Backpressure: hold resp_ready[0]=0 for 10 cycles after resp_valid → resp_r stable, busy=1, no new req_ready; release → return to IDLE next cycle.
- Boundary operands: M=6'b100000 (−32), Q=6'b100000 (−32) → resp_r=12'h400; M=31, Q=−1 → resp_r=12'hFE1.
- Reset asserted in WAIT → all outputs 0 immediately; after release the pending requester is re-granted from rr_ptr=0 and no stale resp_valid appears.
- With BOOTH_ARB_TIMEOUT_EN and TIMEOUT=8: core never asserts mul_done → resp_valid 9 cycles after mul_start with resp_err=1 and resp_r=0; a later spurious mul_done is ignored.
